mem_arbiter: RTL and testbench

- N-client memory request arbiter between the cpu-side requesters and the single memory port of the `memory` block.
- Generalises the single-client afu wiring to NUM_CLIENTS requesters:
  - round-robin grant;
  - bounded outstanding-request tracking;
  - in-order response routing back to the issuing client by client-ID FIFO.
- Sits inside afu, between the clients and `memory`.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arbiter_rr_arbiter.sv | 54 +++++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and defaults for the N-client memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 42;
  localparam int DEF_DATA_W  = 512;

  // Client IDs are sized for the largest supported client count (8), so one
  // ID type serves every legal NUM_CLIENTS setting.
  localparam int MAX_CLIENTS = 8;
  localparam int CLIENT_ID_W = $clog2(MAX_CLIENTS);

  typedef logic [CLIENT_ID_W-1:0] t_client_id;

  // Registered downstream request. Field widths track the package defaults;
  // the arbiter's ADDR_W/DATA_W must match them.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } t_mem_req;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches from i_ptr for the
//                first requester, returns a one-hot grant and the pointer to
//                use after that grant. With MEM_ARB_PRIO_EN defined, client 0
//                has strict priority and its grants leave the pointer alone.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4
) (
  input  logic [NUM_CLIENTS-1:0]         i_req,
  input  logic                           i_en,
  input  logic [$clog2(NUM_CLIENTS)-1:0] i_ptr,
  output logic [NUM_CLIENTS-1:0]         o_grant,
  output logic [$clog2(NUM_CLIENTS)-1:0] o_next_ptr
);

  localparam int c_ptr_w = $clog2(NUM_CLIENTS);

  logic               w_found;
  logic [c_ptr_w-1:0] w_idx;

  // First requester at or after the pointer wins; the pointer moves past it.
  always_comb begin
    o_grant    = '0;
    o_next_ptr = i_ptr;
    w_found    = 1'b0;
    w_idx      = '0;
`ifdef MEM_ARB_PRIO_EN
    if (i_en && i_req[0]) begin
      o_grant[0] = 1'b1;
      w_found    = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      w_idx = c_ptr_w'((int'(i_ptr) + k) % NUM_CLIENTS);
`ifdef MEM_ARB_PRIO_EN
      if (i_en && !w_found && i_req[w_idx] && (w_idx != '0)) begin
`else
      if (i_en && !w_found && i_req[w_idx]) begin
`endif
        o_grant[w_idx] = 1'b1;
        o_next_ptr     = c_ptr_w'((int'(w_idx) + 1) % NUM_CLIENTS);
        w_found        = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : N-client memory request arbiter. Round-robin grant into a
//                single registered downstream request, bounded in-flight
//                tracking, and in-order response routing through a client-ID
//                FIFO. Macro MEM_ARB_PRIO_EN gives client 0 strict priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS     = 4,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                buffer_addr_valid,
  input  logic [NUM_CLIENTS-1:0]              cl_req_valid,
  output logic [NUM_CLIENTS-1:0]              cl_req_ready,
  input  logic [NUM_CLIENTS-1:0]              cl_req_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]       cl_req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0]       cl_req_data,
  output logic [NUM_CLIENTS-1:0]              cl_rsp_valid,
  output logic                                cl_rsp_we,
  output logic [DATA_W-1:0]                   cl_rsp_data,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic                                mem_req_we,
  output logic [ADDR_W-1:0]                   mem_req_addr,
  output logic [DATA_W-1:0]                   mem_req_data,
  input  logic                                mem_rsp_valid,
  input  logic                                mem_rsp_we,
  input  logic [DATA_W-1:0]                   mem_rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
  output logic                                err_unexpected
);

  localparam int c_ptr_w   = $clog2(NUM_CLIENTS);
  localparam int c_fifo_aw = $clog2(MAX_OUTSTANDING);
  localparam int c_cnt_w   = c_fifo_aw + 1;
  localparam logic [NUM_CLIENTS-1:0] c_one = NUM_CLIENTS'(1);

  logic [c_ptr_w-1:0]     r_ptr;
  t_mem_req               r_req;
  logic                   r_req_valid;
  t_client_id             r_fifo [MAX_OUTSTANDING];
  logic [c_fifo_aw-1:0]   r_wr_ptr;
  logic [c_fifo_aw-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]     r_count;
  logic                   r_err;

  logic [NUM_CLIENTS-1:0] w_grant;
  logic [c_ptr_w-1:0]     w_next_ptr;
  t_client_id             w_grant_id;
  t_mem_req               w_sel;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_out_free;
  logic                   w_en;
  logic                   w_push;
  logic                   w_pop;
  t_client_id             w_head;
  logic [NUM_CLIENTS-1:0] w_rsp_onehot;

  // The fullness test uses the registered count, so a same-cycle pop never
  // opens a slot early.
  assign w_full     = (r_count == c_cnt_w'(MAX_OUTSTANDING));
  assign w_empty    = (r_count == '0);
  assign w_out_free = !r_req_valid || mem_req_ready;
  assign w_en       = !rst && buffer_addr_valid && !w_full && w_out_free;
  assign w_push     = |w_grant;
  assign w_pop      = mem_rsp_valid && !w_empty;

  rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_rr (
    .i_req      (cl_req_valid),
    .i_en       (w_en),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_next_ptr (w_next_ptr)
  );

  assign cl_req_ready = w_grant;

  // Encode the one-hot grant and mux out the winning client's request.
  always_comb begin
    w_grant_id = '0;
    w_sel      = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (w_grant[i]) begin
        w_grant_id = t_client_id'(i);
        w_sel.we   = cl_req_we[i];
        w_sel.addr = cl_req_addr[i*ADDR_W +: ADDR_W];
        w_sel.data = cl_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin pointer advances only when a grant is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_push) begin
      r_ptr <= w_next_ptr;
    end
  end

  // Downstream request register: load on grant, hold until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req       <= '0;
      r_req_valid <= 1'b0;
    end else if (w_push) begin
      r_req       <= w_sel;
      r_req_valid <= 1'b1;
    end else if (mem_req_ready) begin
      r_req_valid <= 1'b0;
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_req_we    = r_req.we;
  assign mem_req_addr  = r_req.addr;
  assign mem_req_data  = r_req.data;

  // ID FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_grant_id;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // In-flight count: push and pop together leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag for a response that arrives with nothing in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (mem_rsp_valid && w_empty) begin
      r_err <= 1'b1;
    end
  end

  assign outstanding    = r_count;
  assign err_unexpected = r_err;

  // Route the response to the client at the FIFO head; dropped when empty.
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_rsp_onehot = c_one << w_head;
  assign cl_rsp_valid = w_pop ? w_rsp_onehot : '0;
  assign cl_rsp_we    = w_pop & mem_rsp_we;
  assign cl_rsp_data  = w_pop ? mem_rsp_data : '0;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A reference model holds
//                the expected client-ID queue; IDs are pushed on predicted
//                grants and popped when responses are routed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int MO = 8;

  logic            clk;
  logic            rst;
  logic            buffer_addr_valid;
  logic [N-1:0]    cl_req_valid;
  logic [N-1:0]    cl_req_ready;
  logic [N-1:0]    cl_req_we;
  logic [N*AW-1:0] cl_req_addr;
  logic [N*DW-1:0] cl_req_data;
  logic [N-1:0]    cl_rsp_valid;
  logic            cl_rsp_we;
  logic [DW-1:0]   cl_rsp_data;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic            mem_rsp_valid;
  logic            mem_rsp_we;
  logic [DW-1:0]   mem_rsp_data;
  logic [3:0]      outstanding;
  logic            err_unexpected;

  logic [AW-1:0] c_addr [N];
  logic [DW-1:0] c_data [N];

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model state
  int            m_ptr;
  int            m_idq[$];
  bit            m_vld;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_err;

  logic [N-1:0]  obs_ready;
  logic [N-1:0]  obs_rsp;
  logic [AW-1:0] saved_addr;
  int            order[5] = '{0, 1, 2, 3, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cl_req_addr = '0;
    cl_req_data = '0;
    for (int i = 0; i < N; i++) begin
      cl_req_addr[i*AW +: AW] = c_addr[i];
      cl_req_data[i*DW +: DW] = c_data[i];
    end
  end

  mem_arbiter #(
    .NUM_CLIENTS     (N),
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .buffer_addr_valid (buffer_addr_valid),
    .cl_req_valid      (cl_req_valid),
    .cl_req_ready      (cl_req_ready),
    .cl_req_we         (cl_req_we),
    .cl_req_addr       (cl_req_addr),
    .cl_req_data       (cl_req_data),
    .cl_rsp_valid      (cl_rsp_valid),
    .cl_rsp_we         (cl_rsp_we),
    .cl_rsp_data       (cl_rsp_data),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_we        (mem_req_we),
    .mem_req_addr      (mem_req_addr),
    .mem_req_data      (mem_req_data),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_we        (mem_rsp_we),
    .mem_rsp_data      (mem_rsp_data),
    .outstanding       (outstanding),
    .err_unexpected    (err_unexpected)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] req);
    checks++;
    assert (obs === req) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    int idx;
`ifdef MEM_ARB_PRIO_EN
    if (req[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
`ifdef MEM_ARB_PRIO_EN
      if (idx != 0 && req[idx]) return idx;
`else
      if (req[idx]) return idx;
`endif
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_idq.delete();
    m_vld = 0;
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_err = 0;
  endtask

  // One clock: inputs are set by the caller at the falling edge.
  task automatic cycle();
    int           win;
    bit           elig;
    bit           pop_ok;
    bit           rsp_empty;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp;
    #1;
    elig      = !rst && buffer_addr_valid && (m_idq.size() < MO) && (!m_vld || mem_req_ready);
    win       = elig ? pick(cl_req_valid, m_ptr) : -1;
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    pop_ok    = mem_rsp_valid && (m_idq.size() > 0);
    rsp_empty = mem_rsp_valid && (m_idq.size() == 0);
    exp_rsp   = '0;
    if (pop_ok) exp_rsp[m_idq[0]] = 1'b1;
    obs_ready = cl_req_ready;
    obs_rsp   = cl_rsp_valid;
    check("cl_req_ready", cl_req_ready, exp_ready);
    check("cl_rsp_valid", cl_rsp_valid, exp_rsp);
    check("cl_rsp_we", cl_rsp_we, pop_ok & mem_rsp_we);
    check("cl_rsp_data", cl_rsp_data, pop_ok ? mem_rsp_data : '0);
    check("mem_req_valid", mem_req_valid, m_vld);
    if (m_vld) begin
      check("mem_req_addr", mem_req_addr, m_addr);
      check("mem_req_we", mem_req_we, m_we);
      check("mem_req_data", mem_req_data, m_data);
    end
    check("outstanding", outstanding, m_idq.size());
    check("err_unexpected", err_unexpected, m_err);
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (rsp_empty) m_err = 1;
      if (pop_ok) void'(m_idq.pop_front());
      if (win >= 0) begin
        m_idq.push_back(win);
        m_vld  = 1;
        m_we   = cl_req_we[win];
        m_addr = c_addr[win];
        m_data = c_data[win];
`ifdef MEM_ARB_PRIO_EN
        if (win != 0) m_ptr = (win + 1) % N;
`else
        m_ptr = (win + 1) % N;
`endif
        c_addr[win] = c_addr[win] + 42'h40;
        c_data[win] = ~c_data[win];
      end else if (mem_req_ready) begin
        m_vld = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    buffer_addr_valid = 1'b0;
    cl_req_valid = '0;
    cl_req_we = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_we = 1'b0;
    mem_rsp_data = '0;
    for (int i = 0; i < N; i++) begin
      c_addr[i] = 42'h1000 + AW'(i * 'h100);
      c_data[i] = {16{32'(32'hC0DE0000 + i)}};
    end
    model_reset();
    @(negedge clk);

    // Reset
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("reset_outstanding", outstanding, 4'd0);
    check("reset_mem_req_valid", mem_req_valid, 1'b0);

    // No grants while the buffer address is unprogrammed
    cl_req_valid = 4'hF;
    cycle();
    check("no_bav_ready", obs_ready, 4'h0);

    // All four clients reading: grants 0,1,2,3,0 then routed responses
    buffer_addr_valid = 1'b1;
    mem_req_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      cycle();
`ifndef MEM_ARB_PRIO_EN
      check($sformatf("rr_grant%0d", g), obs_ready, 4'b1 << order[g]);
`endif
    end
    cl_req_valid = '0;
    for (int r = 0; r < 5; r++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 512'hA0 + DW'(r);
      cycle();
`ifndef MEM_ARB_PRIO_EN
      check($sformatf("rr_route%0d", r), obs_rsp, 4'b1 << order[r]);
`endif
    end
    mem_rsp_valid = 1'b0;
    cycle();

    // Nine reads with no responses: eight accepted, ninth stalls
    cl_req_valid = 4'b0010;
    for (int g = 0; g < 9; g++) cycle();
    check("full_ninth_ready", obs_ready, 4'h0);
    check("full_outstanding", outstanding, 4'd8);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 512'hB0;
    cycle();
    check("full_pop_blocks", obs_ready, 4'h0);
    mem_rsp_valid = 1'b0;
    check("after_pop_outstanding", outstanding, 4'd7);
    cycle();
    check("ninth_granted", obs_ready, 4'b0010);
    cl_req_valid = '0;
    mem_rsp_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      mem_rsp_data = 512'hB1 + DW'(r);
      cycle();
    end
    mem_rsp_valid = 1'b0;
    cycle();
    check("drained_outstanding", outstanding, 4'd0);

    // Downstream backpressure: request held stable, no further grants
    mem_req_ready = 1'b0;
    cl_req_valid = 4'b0100;
    saved_addr = c_addr[2];
    cycle();
    for (int s = 0; s < 5; s++) begin
      cycle();
      check("stall_addr", mem_req_addr, saved_addr);
      check("stall_ready", obs_ready, 4'h0);
    end
    mem_req_ready = 1'b1;
    cycle();
    cl_req_valid = '0;
    cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_we = 1'b1;
    cycle();
    cycle();
    mem_rsp_valid = 1'b0;
    mem_rsp_we = 1'b0;
    cycle();

    // Push and pop together at three outstanding
    cl_req_valid = 4'hF;
    for (int g = 0; g < 3; g++) cycle();
    check("pp_pre_outstanding", outstanding, 4'd3);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 512'hC5;
    cycle();
    check("pp_push_seen", obs_ready != 4'h0, 1'b1);
    mem_rsp_valid = 1'b0;
    cl_req_valid = '0;
    check("pp_outstanding", outstanding, 4'd3);

    // Mid-operation reset discards in-flight state; late response is an error
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 512'hDD;
    cycle();
    check("unexp_rsp_valid", obs_rsp, 4'h0);
    mem_rsp_valid = 1'b0;
    check("unexp_err", err_unexpected, 1'b1);
    cycle();
    cycle();
    check("unexp_err_sticky", err_unexpected, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("err_cleared", err_unexpected, 1'b0);

    // Clients 0 and 2 contend
    cl_req_valid = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      cycle();
`ifdef MEM_ARB_PRIO_EN
      check($sformatf("prio_grant%0d", g), obs_ready, 4'b0001);
`else
      check($sformatf("alt_grant%0d", g), obs_ready, (g % 2 == 0) ? 4'b0001 : 4'b0100);
`endif
    end
    cl_req_valid = 4'b0100;
    cycle();
    check("client2_after_drop", obs_ready, 4'b0100);
    cl_req_valid = '0;
    cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
